// File: rtl/branch_redirect.sv
// EX-stage branch resolution: computes outcome and target, detects misprediction and
// issues a registered PC redirect plus IF/ID flush. Optional counters: BR_REDIRECT_STATS_EN.
module branch_redirect #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_ex_valid,
  input  logic            i_stall,
  input  logic            i_is_branch,
  input  logic            i_is_jal,
  input  logic            i_is_jalr,
  input  logic            i_br_success,
  input  logic            i_pred_taken,
  input  logic [XLEN-1:0] i_ex_pc,
  input  logic [XLEN-1:0] i_imm,
  input  logic [XLEN-1:0] i_rs1,
  output logic            o_redirect,
  output logic [XLEN-1:0] o_redirect_pc,
  output logic            o_flush_if,
  output logic            o_flush_id,
  output logic            o_misalign,
  output logic            o_busy
`ifdef BR_REDIRECT_STATS_EN
  ,
  output logic [31:0]     o_br_count,
  output logic [31:0]     o_mispred_count
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_FLUSH    = 2'd2
  } state_e;

  // FLUSH holds FLUSH_CYCLES-1 cycles after the REDIRECT cycle; counter runs down to 0.
  localparam logic [2:0] CNT_INIT = (FLUSH_CYCLES > 1) ? 3'(FLUSH_CYCLES - 2) : 3'd0;

  state_e          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic            misalign_q, misalign_d;

  logic            accept;
  logic            is_ctrl;
  logic            taken;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] fallthru;
  logic            mispredict;
  logic            tgt_misaligned;
  logic            start_redirect;

  assign accept         = i_ex_valid & ~i_stall & (state_q == ST_IDLE);
  assign is_ctrl        = i_is_branch | i_is_jal | i_is_jalr;
  assign taken          = i_is_jal | i_is_jalr | (i_is_branch & i_br_success);
  assign jalr_sum       = i_rs1 + i_imm;
  assign target         = i_is_jalr ? (jalr_sum & ~XLEN'(1)) : (i_ex_pc + i_imm);
  assign fallthru       = i_ex_pc + XLEN'(4);
  assign mispredict     = (taken != i_pred_taken);
  assign tgt_misaligned = taken & target[1];
  // Misaligned taken target suppresses the redirect even when mispredicted.
  assign start_redirect = accept & mispredict & ~tgt_misaligned;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    redirect_pc_d = redirect_pc_q;
    misalign_d    = accept & tgt_misaligned;
    unique case (state_q)
      ST_IDLE: begin
        if (start_redirect) begin
          state_d       = ST_REDIRECT;
          redirect_pc_d = taken ? target : fallthru;
        end
      end
      ST_REDIRECT: begin
        cnt_d   = CNT_INIT;
        state_d = (FLUSH_CYCLES == 1) ? ST_IDLE : ST_FLUSH;
      end
      ST_FLUSH: begin
        if (cnt_q == 3'd0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 3'd0;
      redirect_pc_q <= '0;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      redirect_pc_q <= redirect_pc_d;
      misalign_q    <= misalign_d;
    end
  end

  assign o_redirect    = (state_q == ST_REDIRECT);
  assign o_flush_if    = (state_q != ST_IDLE);
  assign o_flush_id    = (state_q != ST_IDLE);
  assign o_busy        = (state_q != ST_IDLE);
  assign o_misalign    = misalign_q;
  assign o_redirect_pc = redirect_pc_q;

`ifdef BR_REDIRECT_STATS_EN
  logic [31:0] br_count_q, br_count_d;
  logic [31:0] mispred_count_q, mispred_count_d;

  always_comb begin
    br_count_d      = br_count_q + {31'd0, accept & is_ctrl};
    mispred_count_d = mispred_count_q + {31'd0, start_redirect};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      br_count_q      <= 32'd0;
      mispred_count_q <= 32'd0;
    end else begin
      br_count_q      <= br_count_d;
      mispred_count_q <= mispred_count_d;
    end
  end

  assign o_br_count      = br_count_q;
  assign o_mispred_count = mispred_count_q;
`endif

endmodule

// File: tb/tb_branch_redirect.sv
// Bench for branch_redirect: fixed vector table, corner-case sequences and random stimulus,
// all checked against a countdown-based reference model; two DUTs (FLUSH_CYCLES 2 and 1).
module tb_branch_redirect;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, stall, is_branch, is_jal, is_jalr, br_success, pred_taken;
  logic [31:0] ex_pc, imm, rs1;

  logic        redir0, flif0, flid0, mis0, busy0;
  logic [31:0] rpc0;
  logic        redir1, flif1, flid1, mis1, busy1;
  logic [31:0] rpc1;
`ifdef BR_REDIRECT_STATS_EN
  logic [31:0] brc0, mpc0, brc1, mpc1;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  branch_redirect #(.XLEN(32), .FLUSH_CYCLES(2)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_ex_valid(ex_valid), .i_stall(stall),
    .i_is_branch(is_branch), .i_is_jal(is_jal), .i_is_jalr(is_jalr),
    .i_br_success(br_success), .i_pred_taken(pred_taken),
    .i_ex_pc(ex_pc), .i_imm(imm), .i_rs1(rs1),
    .o_redirect(redir0), .o_redirect_pc(rpc0), .o_flush_if(flif0), .o_flush_id(flid0),
    .o_misalign(mis0), .o_busy(busy0)
`ifdef BR_REDIRECT_STATS_EN
    , .o_br_count(brc0), .o_mispred_count(mpc0)
`endif
  );

  branch_redirect #(.XLEN(32), .FLUSH_CYCLES(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_ex_valid(ex_valid), .i_stall(stall),
    .i_is_branch(is_branch), .i_is_jal(is_jal), .i_is_jalr(is_jalr),
    .i_br_success(br_success), .i_pred_taken(pred_taken),
    .i_ex_pc(ex_pc), .i_imm(imm), .i_rs1(rs1),
    .o_redirect(redir1), .o_redirect_pc(rpc1), .o_flush_if(flif1), .o_flush_id(flid1),
    .o_misalign(mis1), .o_busy(busy1)
`ifdef BR_REDIRECT_STATS_EN
    , .o_br_count(brc1), .o_mispred_count(mpc1)
`endif
  );

  // Reference model: remaining flush cycles per DUT instead of an explicit state machine.
  int          fc[2] = '{2, 1};
  int          m_rem[2];
  logic [31:0] m_pc[2];
  logic        m_redir[2], m_mis[2];
  logic [31:0] m_br[2], m_mp[2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_rem[k] = 0; m_pc[k] = 32'd0; m_redir[k] = 1'b0; m_mis[k] = 1'b0;
      m_br[k] = 32'd0; m_mp[k] = 32'd0;
    end
  endtask

  task automatic model_edge();
    logic tk;
    logic [31:0] tgt, ft;
    tk  = is_jal | is_jalr | (is_branch & br_success);
    tgt = is_jalr ? ((rs1 + imm) & 32'hFFFF_FFFE) : (ex_pc + imm);
    ft  = ex_pc + 32'd4;
    for (int k = 0; k < 2; k++) begin
      m_redir[k] = 1'b0;
      m_mis[k]   = 1'b0;
      if (m_rem[k] == 0 && ex_valid && !stall) begin
        if (is_branch | is_jal | is_jalr) m_br[k] = m_br[k] + 1;
        if (tk && tgt[1]) m_mis[k] = 1'b1;
        else if (tk != pred_taken) begin
          m_redir[k] = 1'b1;
          m_pc[k] = tk ? tgt : ft;
          m_mp[k] = m_mp[k] + 1;
        end
      end
      if (m_redir[k]) m_rem[k] = fc[k];
      else if (m_rem[k] > 0) m_rem[k] = m_rem[k] - 1;
    end
  endtask

  task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] pack(input logic r, input logic fi, input logic fd,
                                       input logic m, input logic b, input logic [31:0] pc);
    return {27'd0, r, fi, fd, m, b, pc};
  endfunction

  task automatic check_model();
    logic f0, f1;
    f0 = (m_rem[0] > 0);
    f1 = (m_rem[1] > 0);
    cmp("dut0_outputs", pack(redir0, flif0, flid0, mis0, busy0, rpc0),
        pack(m_redir[0], f0, f0, m_mis[0], f0, m_pc[0]));
    cmp("dut1_outputs", pack(redir1, flif1, flid1, mis1, busy1, rpc1),
        pack(m_redir[1], f1, f1, m_mis[1], f1, m_pc[1]));
`ifdef BR_REDIRECT_STATS_EN
    cmp("dut0_counts", {brc0, mpc0}, {m_br[0], m_mp[0]});
    cmp("dut1_counts", {brc1, mpc1}, {m_br[1], m_mp[1]});
`endif
  endtask

  // One clock: model consumes the inputs present at the edge, then DUTs are compared.
  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
    check_model();
  endtask

  task automatic set_in(input logic v, input logic st, input logic b, input logic j,
                        input logic jr, input logic s, input logic p,
                        input logic [31:0] pc, input logic [31:0] im, input logic [31:0] r1);
    ex_valid = v; stall = st; is_branch = b; is_jal = j; is_jalr = jr;
    br_success = s; pred_taken = p; ex_pc = pc; imm = im; rs1 = r1;
  endtask

  task automatic drain();
    int n;
    set_in(0, 0, 0, 0, 0, 0, 0, 32'd0, 32'd0, 32'd0);
    n = 0;
    while ((busy0 || busy1) && n < 16) begin
      step();
      n++;
    end
    if (busy0 || busy1) begin
      miscompares++;
      $display("FAIL drain_timeout: busy0=%b busy1=%b expected idle", busy0, busy1);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic v, st, b, j, jr, s, p;
    logic [31:0] pc, im, r1;
    logic        exp_redir;
    logic [31:0] exp_pc;
    logic        exp_mis;
  } vec_t;

  vec_t tbl[10];
  int   pulses;

  initial begin
    set_in(0, 0, 0, 0, 0, 0, 0, 32'd0, 32'd0, 32'd0);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    cmp("reset_dut0", pack(redir0, flif0, flid0, mis0, busy0, rpc0), 64'd0);
    cmp("reset_dut1", pack(redir1, flif1, flid1, mis1, busy1, rpc1), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    //                v  st b  j  jr s  p  pc            imm           rs1           redir pc           mis
    tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h100, 32'h20, 32'h0, 1'b1, 32'h120, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 32'h40, 32'h0, 1'b1, 32'h204, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h200, 32'h40, 32'h0, 1'b0, 32'h204, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h80, 32'h4, 32'h1001, 1'b1, 32'h1004, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h6, 32'h0, 1'b0, 32'h1004, 1'b1};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h8, 32'h0, 1'b1, 32'h0, 1'b0};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h300, 32'h8, 32'h0, 1'b0, 32'h0, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h400, 32'h8, 32'h0, 1'b0, 32'h0, 1'b0};
    tbl[8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h40, 32'h10, 32'h3000, 1'b1, 32'h3010, 1'b0};
    tbl[9] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h500, 32'h100, 32'h0, 1'b0, 32'h3010, 1'b0};

    for (int i = 0; i < 10; i++) begin
      set_in(tbl[i].v, tbl[i].st, tbl[i].b, tbl[i].j, tbl[i].jr, tbl[i].s, tbl[i].p,
             tbl[i].pc, tbl[i].im, tbl[i].r1);
      step();
      cmp($sformatf("table_%0d", i), {29'd0, redir0, mis0, flif0, rpc0},
          {29'd0, tbl[i].exp_redir, tbl[i].exp_mis, tbl[i].exp_redir, tbl[i].exp_pc});
      if (i == 0) begin
        set_in(0, 0, 0, 0, 0, 0, 0, 32'd0, 32'd0, 32'd0);
        step();
        cmp("fc2_flush_2nd_cycle", {62'd0, flif0, redir0}, 64'd2);
        cmp("fc1_flush_done", {62'd0, flif1, busy1}, 64'd0);
        step();
        cmp("fc2_flush_done", {62'd0, flif0, busy0}, 64'd0);
      end
      drain();
    end

    // Second mispredicting branch while in REDIRECT/FLUSH must be ignored.
    set_in(1, 0, 1, 0, 0, 1, 0, 32'h600, 32'h40, 32'h0);
    step();
    pulses = int'(redir0);
    set_in(1, 0, 1, 0, 0, 1, 0, 32'h800, 32'h40, 32'h0);
    step(); pulses += int'(redir0);
    set_in(1, 1, 0, 1, 0, 0, 0, 32'h10, 32'h6, 32'h0);
    step(); pulses += int'(redir0);
    cmp("single_redirect", 64'(pulses), 64'd1);
    cmp("redirect_pc_held", {32'd0, rpc0}, {32'd0, 32'h640});
    drain();

    // Asynchronous reset while in FLUSH.
    set_in(1, 0, 1, 0, 0, 0, 1, 32'hFFFF_FFFC, 32'h40, 32'h0);
    step();
    set_in(0, 0, 0, 0, 0, 0, 0, 32'd0, 32'd0, 32'd0);
    step();
    cmp("in_flush_before_reset", {62'd0, flif0, busy0}, 64'd3);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    cmp("async_reset_dut0", pack(redir0, flif0, flid0, mis0, busy0, rpc0), 64'd0);
    cmp("async_reset_dut1", pack(redir1, flif1, flid1, mis1, busy1, rpc1), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef BR_REDIRECT_STATS_EN
    do_reset();
    for (int i = 0; i < 5; i++) begin
      // Entries 1 and 3 mispredict (taken, predicted not-taken).
      set_in(1, 0, 1, 0, 0, 1, (i == 1 || i == 3) ? 1'b0 : 1'b1, 32'h100 + 32'(i * 16),
             32'h20, 32'h0);
      step();
      drain();
    end
    cmp("stats_br_count", {32'd0, brc0}, 64'd5);
    cmp("stats_mispred_count", {32'd0, mpc0}, 64'd2);
`endif

    // Random stimulus against the model.
    for (int n = 0; n < 3000; n++) begin
      logic [2:0] kind;
      kind = 3'($urandom_range(0, 4));
      set_in(($urandom_range(0, 3) != 0), ($urandom_range(0, 5) == 0),
             kind == 3'd0 || kind == 3'd3, kind == 3'd1 || kind == 3'd3, kind == 3'd2,
             1'($urandom), 1'($urandom),
             ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC),
             ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : ($urandom & 32'h0000_FFFC),
             $urandom);
      step();
      if ($urandom_range(0, 499) == 0) do_reset();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
